// File: rtl/wb_write_buffer_pkg.sv
// Shared types and width helpers for the posted-write buffer.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package wb_wbuf_pkg;

  localparam int WB_AWIDTH = 26;
  localparam int WB_DWIDTH = 32;
  localparam int WB_SWIDTH = WB_DWIDTH / 8;

  // Drain FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } wbuf_state_t;

  // One posted write at the default bus widths.
  typedef struct packed {
    logic [WB_AWIDTH-1:0] adr;
    logic [WB_DWIDTH-1:0] dat;
    logic [WB_SWIDTH-1:0] sel;
  } wbuf_entry_t;

  // Flattened entry width {adr, dat, sel} for arbitrary bus widths.
  function automatic int entry_width(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

endpackage

// File: rtl/wb_write_buffer_if.sv
// Wishbone classic bus bundle shared by the arbiter, write buffer and SDRAM controller.
// Latency: none (wires only).
// Backpressure: slave holds off the master by withholding ack.
interface if_wb
  import wb_wbuf_pkg::*;
#(
  parameter int AWIDTH = WB_AWIDTH,
  parameter int DWIDTH = WB_DWIDTH
) ();
  logic [AWIDTH-1:0]   adr;
  logic [DWIDTH-1:0]   dat_m;
  logic [DWIDTH-1:0]   dat_s;
  logic [DWIDTH/8-1:0] sel;
  logic                we;
  logic                cyc;
  logic                stb;
  logic                ack;

  modport master (output adr, dat_m, sel, we, cyc, stb, input dat_s, ack);
  modport slave  (input adr, dat_m, sel, we, cyc, stb, output dat_s, ack);
endinterface

// File: rtl/wb_write_buffer_fifo.sv
// Synchronous FIFO holding posted write entries; head is the oldest entry.
// Latency: push visible at head/level one cycle later; pop frees the slot next cycle.
// Backpressure: push ignored when full, pop ignored when empty.
module wbuf_fifo #(
  parameter int WIDTH = 62,
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_dat,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_head,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_level
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage write; contents need no reset because level gates every read.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr] <= i_dat;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/wb_write_buffer.sv
// Posted-write buffer between arbiter and SDRAM controller; reads wait for all writes to drain.
// Latency: write ack 1 cycle after capture; read ack = downstream latency + 2 cycles.
// Backpressure: upstream writes stall while full; reads stall until the buffer is empty.
module wb_write_buffer
  import wb_wbuf_pkg::*;
#(
  parameter int AWIDTH = WB_AWIDTH,
  parameter int DWIDTH = WB_DWIDTH,
  parameter int DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  if_wb.slave                    inbus,
  if_wb.master                   outbus,
  output logic [$clog2(DEPTH):0] level
);
  localparam int SWIDTH = DWIDTH / 8;
  localparam int EWIDTH = entry_width(AWIDTH, DWIDTH);
  localparam int LWIDTH = $clog2(DEPTH) + 1;

  wbuf_state_t       r_state;
  wbuf_state_t       w_state_nxt;
  logic              r_wack;
  logic              r_abort;
  logic [AWIDTH-1:0] r_rd_adr;
  logic [SWIDTH-1:0] r_rd_sel;
  logic [DWIDTH-1:0] r_rd_dat;
  logic              w_wr_req;
  logic              w_rd_req;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [EWIDTH-1:0] w_tail;
  logic [EWIDTH-1:0] w_head;
  logic [LWIDTH-1:0] w_level;

  assign w_wr_req = inbus.cyc & inbus.stb & inbus.we;
  assign w_rd_req = inbus.cyc & inbus.stb & ~inbus.we;
  // r_wack blocks re-capturing the same request while its ack is on the bus.
  assign w_push   = w_wr_req & ~w_full & ~r_wack;
  assign w_pop    = (r_state == ST_DRAIN) & outbus.ack;
  assign w_tail   = {inbus.adr, inbus.dat_m, inbus.sel};

  wbuf_fifo #(
    .WIDTH (EWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_dat   (w_tail),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign level = w_level;

  // A read whose requester went away still completes downstream but is never acked upstream.
  assign inbus.ack   = r_wack | ((r_state == ST_RESP) & ~r_abort & inbus.cyc);
  assign inbus.dat_s = r_rd_dat;

  // Drain FSM state register; async reset drops the downstream strobe immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and downstream bus drive; drain always wins over a pending read.
  always_comb begin
    w_state_nxt  = r_state;
    outbus.cyc   = 1'b0;
    outbus.stb   = 1'b0;
    outbus.we    = 1'b0;
    outbus.adr   = '0;
    outbus.dat_m = '0;
    outbus.sel   = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty)      w_state_nxt = ST_DRAIN;
        else if (w_rd_req) w_state_nxt = ST_READ;
      end
      ST_DRAIN: begin
        outbus.cyc = 1'b1;
        outbus.stb = 1'b1;
        outbus.we  = 1'b1;
        {outbus.adr, outbus.dat_m, outbus.sel} = w_head;
        if (outbus.ack) w_state_nxt = ST_IDLE;
      end
      ST_READ: begin
        outbus.cyc = 1'b1;
        outbus.stb = 1'b1;
        outbus.adr = r_rd_adr;
        outbus.sel = r_rd_sel;
        if (outbus.ack) w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Write ack pulse, read request latch, abort tracking and read data capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wack   <= 1'b0;
      r_abort  <= 1'b0;
      r_rd_adr <= '0;
      r_rd_sel <= '0;
      r_rd_dat <= '0;
    end else begin
      r_wack <= w_push;
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_READ)) begin
        r_rd_adr <= inbus.adr;
        r_rd_sel <= inbus.sel;
        r_abort  <= 1'b0;
      end else if ((r_state == ST_READ) && !inbus.cyc) begin
        r_abort <= 1'b1;
      end
      if ((r_state == ST_READ) && outbus.ack) r_rd_dat <= outbus.dat_s;
    end
  end
endmodule

// File: tb/tb_wb_write_buffer.sv
// Bench for wb_write_buffer: directed scenarios plus random traffic against a transaction-level model.
// Latency: checks write ack at 1 cycle and idle read ack at downstream latency + 2.
// Backpressure: downstream slave can hold ack off or insert random wait states.
`timescale 1ns/1ps
module tb_wb_write_buffer;
  localparam int AW    = 26;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    bit            we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] level;

  if_wb #(.AWIDTH(AW), .DWIDTH(DW)) bus_in ();
  if_wb #(.AWIDTH(AW), .DWIDTH(DW)) bus_out ();

  wb_write_buffer #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .inbus  (bus_in),
    .outbus (bus_out),
    .level  (level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: expected downstream order, architectural memory, write accounting.
  txn_t          exp_q[$];
  txn_t          mon_t;
  logic [DW-1:0] model_mem [int unsigned];
  logic [DW-1:0] dn_mem    [int unsigned];
  int wr_acked = 0, dn_done = 0, dn_wr_total = 0, dn_rd_done = 0, up_acks = 0, dbl_ack = 0;
  bit prev_ack = 1'b0;
  bit dn_hold  = 1'b0;
  int dn_maxlat = 0, dn_wait = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_start(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    bus_in.adr = a; bus_in.dat_m = d; bus_in.sel = s;
    bus_in.we = 1'b1; bus_in.cyc = 1'b1; bus_in.stb = 1'b1;
  endtask

  task automatic rd_start(input logic [AW-1:0] a);
    bus_in.adr = a; bus_in.dat_m = '0; bus_in.sel = 4'hF;
    bus_in.we = 1'b0; bus_in.cyc = 1'b1; bus_in.stb = 1'b1;
    exp_q.push_back('{we: 1'b0, adr: a, dat: '0, sel: 4'hF});
  endtask

  // Waits for the upstream ack, reports cycles waited, data and level at the ack, then ends the cycle.
  task automatic wait_ack(input string tag, input int max, output int lat,
                          output logic [DW-1:0] d, output int lvl);
    bit got = 1'b0;
    lat = 0; d = '0; lvl = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus_in.ack) begin got = 1'b1; d = bus_in.dat_s; lvl = int'(level); break; end
      lat++;
    end
    chk({tag, "_ack_seen"}, got, 1);
    @(posedge clk); #1;
    bus_in.cyc = 1'b0; bus_in.stb = 1'b0; bus_in.we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (level == 0 && !bus_out.cyc) begin ok = 1'b1; break; end
    end
    chk({tag, "_idle"}, ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Downstream slave: optional hold, random wait states, one-cycle ack, word memory.
  initial begin
    bus_out.ack = 1'b0; bus_out.dat_s = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) bus_out.ack = 1'b0;
      else if (bus_out.ack) bus_out.ack = 1'b0;
      else if (bus_out.cyc && bus_out.stb && !dn_hold) begin
        if (dn_wait > 0) dn_wait--;
        else begin
          bus_out.ack = 1'b1;
          if (bus_out.we) dn_mem[bus_out.adr] = bus_out.dat_m;
          else bus_out.dat_s = dn_mem.exists(bus_out.adr) ? dn_mem[bus_out.adr] : '0;
          dn_wait = $urandom_range(dn_maxlat, 0);
        end
      end
    end
  end

  // Monitor: acked writes enter the expected order; downstream traffic must follow it.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) prev_ack = 1'b0;
      else begin
        if (bus_in.ack && prev_ack) dbl_ack++;
        prev_ack = bus_in.ack;
        if (bus_in.ack) begin
          up_acks++;
          if (bus_in.we) begin
            wr_acked++;
            model_mem[bus_in.adr] = bus_in.dat_m;
            exp_q.push_back('{we: 1'b1, adr: bus_in.adr, dat: bus_in.dat_m, sel: bus_in.sel});
          end
        end
        chk("level", level, 64'(wr_acked - dn_done));
        if (bus_out.cyc && bus_out.stb && bus_out.ack) begin
          if (exp_q.size() == 0) chk("dn_unexpected", 1, 0);
          else begin
            mon_t = exp_q.pop_front();
            chk("dn_we", bus_out.we, mon_t.we);
            chk("dn_adr", bus_out.adr, mon_t.adr);
            if (mon_t.we) begin
              chk("dn_dat", bus_out.dat_m, mon_t.dat);
              chk("dn_sel", bus_out.sel, mon_t.sel);
            end else begin
              chk("rd_after_writes", 64'(wr_acked - dn_done), 0);
              dn_rd_done++;
            end
          end
          if (bus_out.we) begin dn_done++; dn_wr_total++; end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion required finish before 1 ms");
    n_bad++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lvl, base, acks0, seen;
    logic [DW-1:0] d, expd;
    logic [AW-1:0] a;
    bus_in.cyc = 1'b0; bus_in.stb = 1'b0; bus_in.we = 1'b0;
    bus_in.adr = '0; bus_in.dat_m = '0; bus_in.sel = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_cyc", bus_out.cyc, 0);
    chk("rst_out_stb", bus_out.stb, 0);
    chk("rst_out_we", bus_out.we, 0);
    chk("rst_out_adr", bus_out.adr, 0);
    chk("rst_out_dat", bus_out.dat_m, 0);
    chk("rst_out_sel", bus_out.sel, 0);
    chk("rst_in_ack", bus_in.ack, 0);
    chk("rst_in_dat", bus_in.dat_s, 0);
    chk("rst_level", level, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cyc", bus_out.cyc, 0);
    @(posedge clk); #1;

    // Single posted write.
    wr_start(26'h100, 32'hDEADBEEF, 4'hF);
    wait_ack("w1", 10, lat, d, lvl);
    chk("w1_lat", lat, 1);
    chk("w1_level_at_ack", lvl, 1);
    wait_idle("w1");
    chk("w1_dn_writes", dn_wr_total, 1);

    // Five writes against a stalled downstream: fifth waits for the first drain.
    dn_hold = 1'b1;
    base = dn_wr_total;
    for (int i = 0; i < 4; i++) begin
      wr_start(26'h300 + 26'(i * 4), $urandom, 4'(i + 1));
      wait_ack("w29", 10, lat, d, lvl);
      chk("w29_lat", lat, 1);
    end
    wr_start(26'h310, $urandom, 4'hF);
    acks0 = up_acks;
    repeat (8) @(negedge clk);
    chk("w29_fifth_stalled", up_acks - acks0, 0);
    chk("w29_level_full", level, 4);
    dn_hold = 1'b0;
    wait_ack("w29_fifth", 60, lat, d, lvl);
    chk("w29_fifth_after_drain", (dn_wr_total - base) >= 1, 1);
    wait_idle("w29");
    chk("w29_dn_writes", dn_wr_total - base, 5);

    // Write then immediate read of the same address: no bypass, read sees new data.
    dn_maxlat = 2;
    wr_start(26'h200, 32'h55AA, 4'hF);
    wait_ack("w30", 10, lat, d, lvl);
    rd_start(26'h200);
    wait_ack("r30", 60, lat, d, lvl);
    chk("r30_dat", d, 32'h55AA);
    wait_idle("r30");

    // Read on an empty buffer with zero-wait downstream.
    dn_maxlat = 0; dn_wait = 0;
    rd_start(26'h100);
    wait_ack("r_idle", 20, lat, d, lvl);
    chk("r_idle_lat", lat, 2);
    chk("r_idle_dat", d, 32'hDEADBEEF);

    // Requester abandons a read: downstream read completes, no upstream ack.
    dn_hold = 1'b1;
    base = dn_rd_done;
    rd_start(26'h200);
    repeat (3) @(posedge clk);
    #1 bus_in.cyc = 1'b0; bus_in.stb = 1'b0;
    acks0 = up_acks;
    dn_hold = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dn_rd_done != base) begin seen = 1; break; end
    end
    chk("r31_dn_read_done", seen, 1);
    repeat (4) @(negedge clk);
    chk("r31_no_up_ack", up_acks - acks0, 0);
    chk("r31_out_idle", bus_out.cyc, 0);
    @(posedge clk); #1;

    // Enqueue and drain ack in the same cycle at level 2.
    dn_hold = 1'b1;
    base = dn_wr_total;
    wr_start(26'h500, 32'h11110000, 4'h3);
    wait_ack("c33a", 10, lat, d, lvl);
    wr_start(26'h504, 32'h22220000, 4'hC);
    wait_ack("c33b", 10, lat, d, lvl);
    wr_start(26'h508, 32'h33330000, 4'hF);
    dn_wait = 0; dn_hold = 1'b0;
    wait_ack("c33c", 10, lat, d, lvl);
    chk("c33_lat", lat, 1);
    chk("c33_level", lvl, 2);
    wait_idle("c33");
    chk("c33_dn_writes", dn_wr_total - base, 3);

    // Reset during drain with three entries posted.
    dn_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_start(26'h400 + 26'(i * 4), $urandom, 4'hF);
      wait_ack("r32w", 10, lat, d, lvl);
    end
    chk("r32_level_before", level, 3);
    chk("r32_draining", bus_out.cyc, 1);
    base = dn_wr_total;
    #2 rst_n = 1'b0;
    exp_q.delete();
    wr_acked = 0; dn_done = 0;
    #1;
    chk("r32_cyc_dropped", bus_out.cyc, 0);
    chk("r32_stb_dropped", bus_out.stb, 0);
    chk("r32_level_cleared", level, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    dn_hold = 1'b0;
    repeat (10) @(negedge clk);
    chk("r32_no_dn_writes", dn_wr_total - base, 0);
    @(posedge clk); #1;

    // Random mixed traffic against the model.
    dn_maxlat = 3;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
      a = 26'($urandom_range(15, 0) * 4);
      if ($urandom_range(99, 0) < 65) begin
        wr_start(a, $urandom, 4'($urandom_range(15, 1)));
        wait_ack("rnd_wr", 100, lat, d, lvl);
      end else begin
        expd = model_mem.exists(a) ? model_mem[a] : '0;
        rd_start(a);
        wait_ack("rnd_rd", 100, lat, d, lvl);
        chk("rnd_rd_dat", d, expd);
      end
    end
    wait_idle("end");
    chk("end_double_ack", dbl_ack, 0);
    chk("end_queue_empty", exp_q.size(), 0);
    summary();
    $finish;
  end
endmodule
